// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle RV32I+RVX10 controller.
//   - state_t      : controller FSM states
//   - OP_*         : opcode constants (IR[6:0])
//   - ALU_*        : 5-bit ALUControl codes, shared with the alu
//   - alu_op_t     : request from FSM to mc_aludec
//   - *_SRC_*      : select encodings for the datapath muxes
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    EXECX    = 4'd8,
    ALUWB    = 4'd9,
    BEQ      = 4'd10,
    JAL      = 4'd11,
    TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_X      = 7'b0001011;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_SLT  = 5'b00101;
  localparam logic [4:0] ALU_ANDN = 5'b10000;
  localparam logic [4:0] ALU_ORN  = 5'b10001;
  localparam logic [4:0] ALU_XNOR = 5'b10010;
  localparam logic [4:0] ALU_MIN  = 5'b10011;
  localparam logic [4:0] ALU_MAX  = 5'b10100;
  localparam logic [4:0] ALU_MINU = 5'b10101;
  localparam logic [4:0] ALU_MAXU = 5'b10110;
  localparam logic [4:0] ALU_ROL  = 5'b10111;
  localparam logic [4:0] ALU_ROR  = 5'b11000;
  localparam logic [4:0] ALU_ABS  = 5'b11001;

  // ALUOP_FUNCT asks mc_aludec to decode funct3/funct7 for the current op.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [1:0] A_SRC_PC    = 2'b00;
  localparam logic [1:0] A_SRC_OLDPC = 2'b01;
  localparam logic [1:0] A_SRC_A     = 2'b10;

  localparam logic [1:0] B_SRC_B     = 2'b00;
  localparam logic [1:0] B_SRC_IMM   = 2'b01;
  localparam logic [1:0] B_SRC_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_aludec.sv
// mc_aludec: combinational ALU decoder.
//   op, funct3, funct7 : instruction fields from the IR
//   alu_op             : fixed add / fixed sub / decode by funct fields
//   alu_control        : 5-bit ALU operation
//   valid              : funct combination is legal for op (only meaningful
//                        for ALUOP_FUNCT on R, I and X opcodes)
module mc_aludec
  import mc_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  alu_op_t    alu_op,
  output logic [4:0] alu_control,
  output logic       valid
);

  always_comb begin
    alu_control = ALU_ADD;
    valid       = 1'b0;
    case (alu_op)
      ALUOP_ADD: valid = 1'b1;
      ALUOP_SUB: begin
        alu_control = ALU_SUB;
        valid       = 1'b1;
      end
      ALUOP_FUNCT: begin
        if (op == OP_R || op == OP_I) begin
          valid = 1'b1;
          case (funct3)
            3'b000: alu_control = (op == OP_R && funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
            3'b010: alu_control = ALU_SLT;
            3'b110: alu_control = ALU_OR;
            3'b111: alu_control = ALU_AND;
            default: valid = 1'b0;
          endcase
          // Register form only allows funct7=0, plus 0100000 for sub.
          if (op == OP_R && !(funct7 == 7'b0000000 ||
                              (funct7 == 7'b0100000 && funct3 == 3'b000)))
            valid = 1'b0;
        end else if (op == OP_X) begin
          valid = 1'b1;
          case ({funct7, funct3})
            10'b0000000_000: alu_control = ALU_ANDN;
            10'b0000000_001: alu_control = ALU_ORN;
            10'b0000000_010: alu_control = ALU_XNOR;
            10'b0000001_000: alu_control = ALU_MIN;
            10'b0000001_001: alu_control = ALU_MAX;
            10'b0000001_010: alu_control = ALU_MINU;
            10'b0000001_011: alu_control = ALU_MAXU;
            10'b0000010_000: alu_control = ALU_ROL;
            10'b0000010_001: alu_control = ALU_ROR;
            10'b0000011_000: alu_control = ALU_ABS;
            default:         valid       = 1'b0;
          endcase
        end
      end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: sequencing FSM for a multicycle RV32I+RVX10 datapath
// with one shared instruction/data memory.
//   clk, reset (async, active low)
//   op/funct3/funct7 : IR fields;  Zero : ALU zero flag
//   mem_ready        : memory completes the current access this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
//   RegWrite, ALUControl : datapath controls
//   instr_done       : pulse on the last state of each retired instruction
//   illegal          : high while trapped
//   state_dbg        : current FSM state (state_t encoding)
// Handshake: a memory access is presented every cycle in FETCH, MEMREAD or
// MEMWRITE and completes on the first cycle mem_ready is sampled high; enables
// that depend on completion are gated by mem_ready in that same cycle.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [4:0] ALUControl,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  state_t     state_q, state_d;
  alu_op_t    alu_op;
  logic [4:0] dec_alu_control;
  logic       dec_valid;
  logic       legal;
  logic       pc_write, mem_write, ir_write, reg_write, done, trapped;

  mc_aludec u_aludec (
    .op          (op),
    .funct3      (funct3),
    .funct7      (funct7),
    .alu_op      (alu_op),
    .alu_control (dec_alu_control),
    .valid       (dec_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Legality is judged in DECODE so EXEC* states never see an illegal code.
  always_comb begin
    case (op)
      OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL: legal = 1'b1;
      OP_R, OP_I, OP_X:                     legal = dec_valid;
      default:                              legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    alu_op     = ALUOP_ADD;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = A_SRC_PC;
    ALUSrcB    = B_SRC_B;
    ImmSrc     = IMM_I;
    ALUControl = ALU_ADD;
    pc_write   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    done       = 1'b0;
    trapped    = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcB   = B_SRC_FOUR;
        ResultSrc = RES_ALURES;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcA = A_SRC_OLDPC;
        ALUSrcB = B_SRC_IMM;
        alu_op  = ALUOP_FUNCT;   // only for dec_valid; ALUControl stays add
        case (op)
          OP_STORE:  ImmSrc = IMM_S;
          OP_BRANCH: ImmSrc = IMM_B;
          OP_JAL:    ImmSrc = IMM_J;
          default:   ImmSrc = IMM_I;
        endcase
        if (!legal) begin
          if (TRAP_ON_ILLEGAL != 0) begin
            state_d = TRAP;
          end else begin
            done    = 1'b1;
            state_d = FETCH;
          end
        end else begin
          case (op)
            OP_LOAD, OP_STORE: state_d = MEMADR;
            OP_R:              state_d = EXECR;
            OP_I:              state_d = EXECI;
            OP_BRANCH:         state_d = BEQ;
            OP_JAL:            state_d = JAL;
            default:           state_d = EXECX;
          endcase
        end
      end
      MEMADR: begin
        ALUSrcA = A_SRC_A;
        ALUSrcB = B_SRC_IMM;
        ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
        state_d = (op == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          done    = 1'b1;
          state_d = FETCH;
        end
      end
      EXECR, EXECX: begin
        ALUSrcA    = A_SRC_A;
        alu_op     = ALUOP_FUNCT;
        ALUControl = dec_alu_control;
        state_d    = ALUWB;
      end
      EXECI: begin
        ALUSrcA    = A_SRC_A;
        ALUSrcB    = B_SRC_IMM;
        alu_op     = ALUOP_FUNCT;
        ALUControl = dec_alu_control;
        state_d    = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = FETCH;
      end
      BEQ: begin
        ALUSrcA    = A_SRC_A;
        alu_op     = ALUOP_SUB;
        ALUControl = dec_alu_control;
        pc_write   = Zero;
        done       = 1'b1;
        state_d    = FETCH;
      end
      JAL: begin
        // PC <- target already held in ALUOut; ALU forms OldPC+4 for rd.
        ALUSrcA  = A_SRC_OLDPC;
        ALUSrcB  = B_SRC_FOUR;
        pc_write = 1'b1;
        state_d  = ALUWB;
      end
      TRAP: trapped = 1'b1;
      default: state_d = FETCH;
    endcase
  end

  // Reset gates every enable directly so nothing writes while reset is low,
  // even though the state register already reads FETCH.
  assign PCWrite    = reset & pc_write;
  assign MemWrite   = reset & mem_write;
  assign IRWrite    = reset & ir_write;
  assign RegWrite   = reset & reg_write;
  assign instr_done = reset & done;
  assign illegal    = reset & trapped;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: each instruction is described by
// its expected state sequence (one entry per cycle) plus expected enable
// counts; mem_ready stalls wherever the sequence repeats a memory state.
module tb_multicycle_controller;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [4:0] ALUControl;
  logic [3:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];

  multicycle_controller #(.TRAP_ON_ILLEGAL(1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .ALUControl(ALUControl), .instr_done(instr_done), .illegal(illegal),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Holds reset low for two cycles, checking the gated enables, then
  // releases it with mem_ready low so the first FETCH is seen by run_instr.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("rst state", state_dbg, FETCH);
    check("rst PCWrite", PCWrite, 0);
    check("rst IRWrite", IRWrite, 0);
    check("rst illegal", illegal, 0);
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b1;
  endtask

  // ---------------- driver + scoreboard ----------------
  task automatic push(input state_t s, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(s);
  endtask

  task automatic run_instr(input string name, input logic [31:0] instr, input logic zero_in,
                           input int exp_pcw, input int exp_regw, input int exp_memw,
                           input int exp_done, input logic [4:0] exp_alu,
                           input logic [1:0] exp_imm);
    int pcw = 0, regw = 0, memw = 0, done = 0;
    logic [3:0] s;
    logic is_exec;
    op = instr[6:0];
    funct3 = instr[14:12];
    funct7 = instr[31:25];
    while (exp_q.size() > 0) begin
      @(negedge clk);
      s = exp_q.pop_front();
      mem_ready = !((s == FETCH || s == MEMREAD || s == MEMWRITE) &&
                    exp_q.size() > 0 && exp_q[0] == s);
      Zero = zero_in;
      #1;
      is_exec = (s == EXECR || s == EXECI || s == EXECX || s == BEQ);
      check({name, " state"}, state_dbg, s);
      check({name, " ALUControl"}, ALUControl, is_exec ? exp_alu : ALU_ADD);
      check({name, " illegal"}, illegal, s == TRAP);
      check({name, " MemWrite&RegWrite"}, MemWrite & RegWrite, 0);
      if (s != FETCH) check({name, " IRWrite outside FETCH"}, IRWrite, 0);
      if (s == MEMADR) check({name, " ImmSrc MEMADR"}, ImmSrc, exp_imm);
      if (s == MEMREAD) check({name, " AdrSrc MEMREAD"}, AdrSrc, 1);
      if (s == MEMWB) check({name, " ResultSrc MEMWB"}, ResultSrc, RES_DATA);
      if (s == TRAP) check({name, " PCWrite TRAP"}, PCWrite, 0);
      pcw  += int'(PCWrite);
      regw += int'(RegWrite);
      memw += int'(MemWrite);
      done += int'(instr_done);
    end
    check({name, " PCWrite count"}, pcw, exp_pcw);
    check({name, " RegWrite count"}, regw, exp_regw);
    check({name, " MemWrite count"}, memw, exp_memw);
    check({name, " instr_done count"}, done, exp_done);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();

    // add x3,x1,x2
    push(FETCH, 1); push(DECODE, 1); push(EXECR, 1); push(ALUWB, 1);
    run_instr("add", 32'h002081B3, 1'b0, 1, 1, 0, 1, ALU_ADD, IMM_I);

    // sub, with one fetch stall
    push(FETCH, 2); push(DECODE, 1); push(EXECR, 1); push(ALUWB, 1);
    run_instr("sub", 32'h402081B3, 1'b0, 1, 1, 0, 1, ALU_SUB, IMM_I);

    // slt and addi
    push(FETCH, 1); push(DECODE, 1); push(EXECR, 1); push(ALUWB, 1);
    run_instr("slt", 32'h0020A1B3, 1'b0, 1, 1, 0, 1, ALU_SLT, IMM_I);
    push(FETCH, 1); push(DECODE, 1); push(EXECI, 1); push(ALUWB, 1);
    run_instr("addi", 32'h00108093, 1'b0, 1, 1, 0, 1, ALU_ADD, IMM_I);

    // lw with two MEMREAD stalls: 7 cycles
    push(FETCH, 1); push(DECODE, 1); push(MEMADR, 1); push(MEMREAD, 3); push(MEMWB, 1);
    run_instr("lw", 32'h0000A183, 1'b0, 1, 1, 0, 1, ALU_ADD, IMM_I);

    // sw with three MEMWRITE stalls: MemWrite for 4 cycles
    push(FETCH, 1); push(DECODE, 1); push(MEMADR, 1); push(MEMWRITE, 4);
    run_instr("sw", 32'h0020A023, 1'b0, 1, 0, 4, 1, ALU_ADD, IMM_S);

    // beq taken / not taken
    push(FETCH, 1); push(DECODE, 1); push(BEQ, 1);
    run_instr("beq_taken", 32'h00000063, 1'b1, 2, 0, 0, 1, ALU_SUB, IMM_B);
    push(FETCH, 1); push(DECODE, 1); push(BEQ, 1);
    run_instr("beq_not", 32'h00000063, 1'b0, 1, 0, 0, 1, ALU_SUB, IMM_B);

    // jal
    push(FETCH, 1); push(DECODE, 1); push(JAL, 1); push(ALUWB, 1);
    run_instr("jal", 32'h0000006F, 1'b0, 2, 1, 0, 1, ALU_ADD, IMM_J);

    // RVX10 rol and abs
    push(FETCH, 1); push(DECODE, 1); push(EXECX, 1); push(ALUWB, 1);
    run_instr("rol", 32'h0420818B, 1'b0, 1, 1, 0, 1, ALU_ROL, IMM_I);
    push(FETCH, 1); push(DECODE, 1); push(EXECX, 1); push(ALUWB, 1);
    run_instr("abs", 32'h0620818B, 1'b0, 1, 1, 0, 1, ALU_ABS, IMM_I);

    // illegal RVX10 funct7 -> sticky TRAP
    push(FETCH, 1); push(DECODE, 1); push(TRAP, 4);
    run_instr("x_illegal", 32'h0820818B, 1'b0, 1, 0, 0, 0, ALU_ADD, IMM_I);
    do_reset();

    // illegal R-type funct7 also traps
    push(FETCH, 1); push(DECODE, 1); push(TRAP, 2);
    run_instr("r_illegal", 32'h022081B3, 1'b0, 1, 0, 0, 0, ALU_ADD, IMM_I);
    do_reset();

    // reset asserted in MEMWRITE while the store is stalled
    push(FETCH, 1); push(DECODE, 1); push(MEMADR, 1);
    run_instr("sw_pre", 32'h0020A023, 1'b0, 1, 0, 0, 0, ALU_ADD, IMM_S);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("midrst state MEMWRITE", state_dbg, MEMWRITE);
    check("midrst MemWrite before", MemWrite, 1);
    #1;
    reset = 1'b0;
    #1;
    check("midrst MemWrite async", MemWrite, 0);
    check("midrst state", state_dbg, FETCH);
    mem_ready = 1'b1;
    #1;
    check("midrst IRWrite gated", IRWrite, 0);
    check("midrst PCWrite gated", PCWrite, 0);
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("post-rst state", state_dbg, FETCH);
    check("post-rst illegal", illegal, 0);
    check("post-rst MemWrite", MemWrite, 0);

    // add runs normally after recovery
    push(FETCH, 1); push(DECODE, 1); push(EXECR, 1); push(ALUWB, 1);
    run_instr("add_after", 32'h002081B3, 1'b0, 1, 1, 0, 1, ALU_ADD, IMM_I);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
